// File: rtl/pacman_anim_ctrl_if.sv
// Game-logic <-> animation sequencer bundle for the Pac-Man sprite.
// Optional freeze input exists only when PACMAN_ANIM_FREEZE_EN is defined.
interface pacman_anim_ctrl_if;
  logic       frame_tick;
  logic [1:0] dir_in;
  logic       moving;
  logic       dying;
  logic [1:0] mouth;
  logic [1:0] dir_out;
  logic       death_active;
  logic [3:0] death_frame;
  logic       anim_done;
`ifdef PACMAN_ANIM_FREEZE_EN
  logic       freeze;

  modport master (
    output frame_tick, dir_in, moving, dying, freeze,
    input  mouth, dir_out, death_active, death_frame, anim_done
  );
  modport slave (
    input  frame_tick, dir_in, moving, dying, freeze,
    output mouth, dir_out, death_active, death_frame, anim_done
  );
`else
  modport master (
    output frame_tick, dir_in, moving, dying,
    input  mouth, dir_out, death_active, death_frame, anim_done
  );
  modport slave (
    input  frame_tick, dir_in, moving, dying,
    output mouth, dir_out, death_active, death_frame, anim_done
  );
`endif
endinterface

// File: rtl/pacman_anim_ctrl.sv
// Frame-synchronous Pac-Man sprite sequencer: mouth pose, facing and death frames.
// Optional pause input enabled by defining PACMAN_ANIM_FREEZE_EN.
module pacman_anim_ctrl #(
  parameter int FRAMES_PER_STEP = 4,
  parameter int DEATH_FRAMES    = 11
) (
  input logic              vga_clk,
  input logic              rst,
  pacman_anim_ctrl_if.slave bus
);
  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    DF_LAST  = 4'(DEATH_FRAMES - 1);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    FULL    = 3'd2,
    CLOSING = 3'd3,
    DEATH   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          frz;
  logic          tick;
  logic          wrap;

`ifdef PACMAN_ANIM_FREEZE_EN
  assign frz = bus.freeze;
`else
  assign frz = 1'b0;
`endif
  // A frozen frame is treated as if no vertical blank happened at all.
  assign tick = bus.frame_tick & ~frz;
  assign wrap = (cnt == CNT_LAST);

  function automatic state_t mouth_next(input state_t s);
    case (s)
      CLOSED:  return OPENING;
      OPENING: return FULL;
      FULL:    return CLOSING;
      default: return CLOSED;
    endcase
  endfunction

  function automatic logic [1:0] mouth_code(input state_t s);
    case (s)
      OPENING, CLOSING: return 2'd1;
      FULL:             return 2'd2;
      default:          return 2'd0;
    endcase
  endfunction

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state            <= CLOSED;
      cnt              <= {CW{1'b0}};
      bus.mouth        <= 2'd0;
      bus.dir_out      <= 2'd0;
      bus.death_active <= 1'b0;
      bus.death_frame  <= 4'd0;
      bus.anim_done    <= 1'b0;
    end else begin
      case (state)
        CLOSED, OPENING, FULL, CLOSING: begin
          if (tick) begin
            bus.dir_out <= bus.dir_in;
          end
          // Death preempts any pending mouth step on the same edge.
          if (bus.dying) begin
            state            <= DEATH;
            cnt              <= {CW{1'b0}};
            bus.mouth        <= 2'd0;
            bus.death_active <= 1'b1;
            bus.death_frame  <= 4'd0;
          end else if (tick && bus.moving) begin
            if (wrap) begin
              cnt       <= {CW{1'b0}};
              state     <= mouth_next(state);
              bus.mouth <= mouth_code(mouth_next(state));
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        DEATH: begin
          if (tick) begin
            if (wrap) begin
              cnt <= {CW{1'b0}};
              if (bus.death_frame == DF_LAST) begin
                state         <= DONE;
                bus.anim_done <= 1'b1;
              end else begin
                bus.death_frame <= bus.death_frame + 4'd1;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        DONE: begin
          if (!bus.dying && !frz) begin
            state            <= CLOSED;
            cnt              <= {CW{1'b0}};
            bus.mouth        <= 2'd0;
            bus.dir_out      <= 2'd0;
            bus.death_active <= 1'b0;
            bus.death_frame  <= 4'd0;
            bus.anim_done    <= 1'b0;
          end
        end
        default: begin
          state            <= CLOSED;
          cnt              <= {CW{1'b0}};
          bus.mouth        <= 2'd0;
          bus.dir_out      <= 2'd0;
          bus.death_active <= 1'b0;
          bus.death_frame  <= 4'd0;
          bus.anim_done    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pacman_anim_ctrl.sv
// Self-checking bench for pacman_anim_ctrl: directed test-plan steps plus random
// frames, compared against a tick-counting reference model.
module tb_pacman_anim_ctrl;
  localparam int F  = 4;
  localparam int DF = 11;

  logic vga_clk = 1'b0;
  logic rst     = 1'b1;
  int   tests   = 0;
  int   fails   = 0;

  // Reference model: mouth phase derived from count of moving ticks,
  // death frame derived from count of ticks since death began.
  int   m_mode;
  int   m_n;
  int   m_d;
  int   m_dir;

  pacman_anim_ctrl_if bus ();

  pacman_anim_ctrl #(.FRAMES_PER_STEP(F), .DEATH_FRAMES(DF)) dut (
    .vga_clk (vga_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic get_frz();
`ifdef PACMAN_ANIM_FREEZE_EN
    return bus.freeze;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int phase_mouth(input int p);
    case (p)
      1, 3:    return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_d = 0; m_dir = 0;
  endtask

  task automatic model_update();
    logic t;
    t = bus.frame_tick && !get_frz();
    if (rst) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (t) m_dir = int'(bus.dir_in);
      if (bus.dying) begin
        m_mode = 1; m_d = 0; m_n = 0;
      end else if (t && bus.moving) begin
        m_n = (m_n + 1) % (4 * F);
      end
    end else if (m_mode == 1) begin
      if (t) begin
        m_d = m_d + 1;
        if (m_d == F * DF) m_mode = 2;
      end
    end else begin
      if (!bus.dying && !get_frz()) begin
        m_mode = 0; m_n = 0; m_d = 0; m_dir = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int em, edf, eda, edn;
    em  = (m_mode == 0) ? phase_mouth(m_n / F) : 0;
    edf = (m_mode == 0) ? 0 : ((m_mode == 1) ? m_d / F : DF - 1);
    eda = (m_mode == 0) ? 0 : 1;
    edn = (m_mode == 2) ? 1 : 0;
    chk("mouth",        32'(bus.mouth),        32'(em));
    chk("dir_out",      32'(bus.dir_out),      32'(m_dir));
    chk("death_active", 32'(bus.death_active), 32'(eda));
    chk("death_frame",  32'(bus.death_frame),  32'(edf));
    chk("anim_done",    32'(bus.anim_done),    32'(edn));
  endtask

  task automatic cyc(input logic t);
    bus.frame_tick = t;
    model_update();
    @(posedge vga_clk);
    #1;
    bus.frame_tick = 1'b0;
    check_all();
  endtask

  task automatic frames(input int k);
    for (int i = 0; i < k; i++) begin
      cyc(1'b1);
      repeat (3) cyc(1'b0);
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.dir_in     = 2'd0;
    bus.moving     = 1'b0;
    bus.dying      = 1'b0;
`ifdef PACMAN_ANIM_FREEZE_EN
    bus.freeze     = 1'b0;
`endif
    model_reset();
    #3;
    check_all();
    @(posedge vga_clk);
    #1;
    rst = 1'b0;
    check_all();

    // Mouth cycle with facing up.
    bus.moving = 1'b1;
    bus.dir_in = 2'd2;
    frames(16);
    chk("mouth_after_16", 32'(bus.mouth), 32'd0);

    // Pause mid-step, then resume.
    bus.dir_in = 2'd0;
    frames(5);
    bus.moving = 1'b0;
    frames(6);
    bus.moving = 1'b1;
    frames(3);
    chk("mouth_resume", 32'(bus.mouth), 32'd2);

    // Direction change between ticks.
    bus.dir_in = 2'd3;
    repeat (2) cyc(1'b0);
    chk("dir_hold", 32'(bus.dir_out), 32'd0);
    frames(1);

    // Death sequence, dying dropped mid-way; exits DONE immediately.
    frames(1);
    bus.dying = 1'b1;
    cyc(1'b0);
    chk("death_entry", 32'(bus.death_active), 32'd1);
    repeat (3) cyc(1'b0);
    frames(20);
    bus.dying = 1'b0;
    frames(24);
    repeat (4) cyc(1'b0);

    // Death held until well after DONE.
    bus.dying = 1'b1;
    frames(46);
    chk("done_held", 32'(bus.anim_done), 32'd1);
    bus.dying = 1'b0;
    cyc(1'b0);
    chk("done_exit", 32'(bus.anim_done), 32'd0);

`ifdef PACMAN_ANIM_FREEZE_EN
    bus.freeze = 1'b1;
    frames(8);
    bus.freeze = 1'b0;
    frames(2);
`endif

    // Randomized frames.
    for (int i = 0; i < 2500; i++) begin
      bus.dir_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) bus.moving = ~bus.moving;
      if ($urandom_range(0, 149) == 0) bus.dying = ~bus.dying;
`ifdef PACMAN_ANIM_FREEZE_EN
      if ($urandom_range(0, 39) == 0) bus.freeze = ~bus.freeze;
`endif
      cyc($urandom_range(0, 3) == 0);
    end
`ifdef PACMAN_ANIM_FREEZE_EN
    bus.freeze = 1'b0;
`endif

    // Async reset while death_frame is 5.
    bus.dying = 1'b0;
    repeat (8) cyc(1'b0);
    bus.dying = 1'b1;
    begin
      int budget;
      budget = 0;
      while (!(m_mode == 1 && m_d / F == 5) && budget < 600) begin
        cyc(budget % 4 == 0);
        budget++;
      end
      chk("reach_df5", 32'(budget < 600), 32'd1);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    bus.dying = 1'b0;
    @(posedge vga_clk);
    #1;
    rst = 1'b0;
    bus.moving = 1'b1;
    frames(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pacman_anim_ctrl.md
Name: pacman_anim_ctrl

Overview:
- Frame-synchronous animation sequencer for the Pac-Man sprite.
- Decides every frame which sprite ROM/palette mapper drives the pixel path: mouth pose × facing direction, or a death-sequence frame.
- Sits between the game-logic block (direction, moving, dying) and the sprite mapper mux; sprite selects change only at frame boundaries, so no sprite tearing occurs mid-scan.

Parameters:
- FRAMES_PER_STEP, 4, frame_tick pulses per animation step (≥1).
- DEATH_FRAMES, 11, number of death-sequence sprites (2..16).

Ports:
- vga_clk  in  1  pixel clock, all logic on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- dir_in  in  2  requested facing: 0 right, 1 left, 2 up, 3 down.
- moving  in  1  level; 1 = Pac-Man advancing this frame.
- dying  in  1  level; 1 = death in progress.
- mouth  out  2  0 closed, 1 half open, 2 full open (3 never driven).
- dir_out  out  2  latched facing sent to the mapper mux.
- death_active  out  1  1 while in DEATH or DONE.
- death_frame  out  4  death sprite index, 0..DEATH_FRAMES-1.
- anim_done  out  1  1 while in DONE.

Behaviour:
- Reset (async): state CLOSED, step counter 0, mouth 0, dir_out 0, death_active 0, death_frame 0, anim_done 0. All outputs are registered.
- Step counter cnt (width clog2(FRAMES_PER_STEP), minimum 1 bit):
  - Increments on frame_tick when counting is enabled.
  - step_evt = frame_tick AND cnt==FRAMES_PER_STEP-1; on step_evt, cnt wraps to 0.
  - FRAMES_PER_STEP=1 gives step_evt on every tick.
- Counting enabled:
  - Mouth states: only when moving=1. With moving=0, cnt and state hold.
  - DEATH: always.
- dir_out loads dir_in on every frame_tick unless state is DEATH or DONE. Between ticks it holds.
- Mouth states, advanced on step_evt:
  - CLOSED → OPENING → FULL → CLOSING → CLOSED.
  - mouth outputs: CLOSED=0, OPENING=1, FULL=2, CLOSING=1.
  - Outputs update the cycle after the transition edge, i.e. one vga_clk latency from the frame_tick.
- Death:
  - dying=1 in any mouth state → DEATH on the next edge, independent of frame_tick.
  - On entry: cnt=0, death_frame=0, death_active=1, mouth=0.
- DEATH:
  - Each step_evt increments death_frame.
  - On step_evt with death_frame==DEATH_FRAMES-1 → DONE; death_frame holds at DEATH_FRAMES-1.
  - dying falling to 0 during DEATH is ignored; the sequence always completes.
- DONE:
  - anim_done=1; outputs held.
  - When dying=0 → CLOSED on the next edge with cnt=0. death_active, death_frame and anim_done clear, dir_out resets to 0.
- Simultaneous events:
  - dying=1 with step_evt in a mouth state: death wins, no mouth advance.
  - frame_tick with a dir_in change: the new direction takes effect in the same update.
- Reset mid-DEATH: immediate return to reset values. No residual count.

Optional Feature:
- Macro PACMAN_ANIM_FREEZE_EN.
- Defined:
  - Adds input port freeze (1 bit, level). While freeze=1, cnt, state, dir_out and all outputs hold, and frame_tick is ignored. Used for level-start and ghost-eaten pauses.
  - dying=1 still forces entry to DEATH. DEATH then advances only when freeze=0.
- Not defined: no freeze port; behaviour as above.

Test Plan:
- Reset released, moving=1, dir_in=2, FRAMES_PER_STEP=4, 16 frame_ticks → mouth sequence 0,1,2,1,0 changing after ticks 4,8,12,16; dir_out=2 after the first tick.
- moving=1 for 5 ticks, then moving=0 for 6 ticks, then moving=1 for 3 ticks → mouth=1 after tick 4 and held through the pause; becomes 2 on tick 14 (cnt resumes from 1).
- dir_in changes 0→3 between ticks → dir_out stays 0 until the next frame_tick, then 3 one cycle later.
- dying=1 while mouth=2 → next cycle death_active=1, mouth=0, death_frame=0. With DEATH_FRAMES=11 and 4 ticks/step: death_frame reaches 10 after 40 ticks, anim_done=1 at tick 44. Dropping dying at tick 20 does not abort.
- In DONE, dying→0 → next cycle state CLOSED, anim_done=0, death_active=0, dir_out=0.
- Reset asserted while death_frame=5 → all outputs 0 asynchronously. With PACMAN_ANIM_FREEZE_EN and freeze=1, 8 ticks → no output change.
